// File: rtl/sirc_rx_decoder.sv
// Sony SIRC receiver: measures demodulated IR burst and gap widths in ticks and
// assembles 12/15/20-bit frames into command/address, reporting malformed frames.
module sirc_rx_decoder #(
    parameter int NBITS      = 12,
    parameter int TICK_DIV   = 2025,
    parameter int START_MIN  = 28,
    parameter int START_MAX  = 40,
    parameter int HIGH_MIN   = 4,
    parameter int BIT_THRESH = 12,
    parameter int HIGH_MAX   = 24,
    parameter int LOW_MAX    = 16,
    parameter int ONESHOT    = 1
) (
    input  logic             clock_27mhz,
    input  logic             reset,
    input  logic             ir_in,
    input  logic             arm,
    output logic             valid,
    output logic [6:0]       command,
    output logic [NBITS-8:0] address,
    output logic             error,
    output logic [1:0]       err_code,
    output logic             busy,
    output logic [2:0]       debug_state
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [5:0] START_MIN_T  = 6'(START_MIN);
    localparam logic [5:0] START_MAX_T  = 6'(START_MAX);
    localparam logic [5:0] HIGH_MIN_T   = 6'(HIGH_MIN);
    localparam logic [5:0] BIT_THRESH_T = 6'(BIT_THRESH);
    localparam logic [5:0] HIGH_MAX_T   = 6'(HIGH_MAX);
    localparam logic [5:0] LOW_MAX_T    = 6'(LOW_MAX);
    localparam logic [4:0] LAST_BIT     = 5'(NBITS - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        START_HI = 3'd1,
        GAP      = 3'd2,
        BIT_HI   = 3'd3,
        DONE     = 3'd4,
        ERR      = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic              irMeta_q, irSync_q, irPrev_q;
    logic [PW-1:0]     presc_q, presc_d;
    logic [5:0]        ticks_q, ticks_d;
    logic [4:0]        bitpos_q, bitpos_d;
    logic [NBITS-1:0]  shift_q, shift_d;
    logic              armPend_q, armPend_d;
    logic [1:0]        errPend_q, errPend_d;
    logic              valid_q, valid_d;
    logic              error_q, error_d;
    logic [6:0]        cmd_q, cmd_d;
    logic [NBITS-8:0]  addr_q, addr_d;
    logic [1:0]        errCode_q, errCode_d;

    logic              tickNow;
    logic [5:0]        ticksNow;
    logic              rise, fall, armed;

    always_ff @(posedge clock_27mhz) begin
        if (reset) begin
            irMeta_q  <= 1'b0;
            irSync_q  <= 1'b0;
            irPrev_q  <= 1'b0;
            state_q   <= IDLE;
            presc_q   <= '0;
            ticks_q   <= '0;
            bitpos_q  <= '0;
            shift_q   <= '0;
            armPend_q <= 1'b0;
            errPend_q <= '0;
            valid_q   <= 1'b0;
            error_q   <= 1'b0;
            cmd_q     <= '0;
            addr_q    <= '0;
            errCode_q <= '0;
        end else begin
            irMeta_q  <= ir_in;
            irSync_q  <= irMeta_q;
            irPrev_q  <= irSync_q;
            state_q   <= state_d;
            presc_q   <= presc_d;
            ticks_q   <= ticks_d;
            bitpos_q  <= bitpos_d;
            shift_q   <= shift_d;
            armPend_q <= armPend_d;
            errPend_q <= errPend_d;
            valid_q   <= valid_d;
            error_q   <= error_d;
            cmd_q     <= cmd_d;
            addr_q    <= addr_d;
            errCode_q <= errCode_d;
        end
    end

    // Decisions use the tick count including the current cycle, so a width of
    // exactly k ticks (measured between synced edges) reads as k.
    always_comb begin
        tickNow  = (presc_q == PRESC_MAX);
        ticksNow = (tickNow && ticks_q != 6'd63) ? ticks_q + 6'd1 : ticks_q;
        rise     = irSync_q & ~irPrev_q;
        fall     = ~irSync_q & irPrev_q;
        armed    = (ONESHOT == 0) || armPend_q;

        state_d   = state_q;
        bitpos_d  = bitpos_q;
        shift_d   = shift_q;
        armPend_d = armPend_q;
        errPend_d = errPend_q;
        valid_d   = 1'b0;
        error_d   = 1'b0;
        cmd_d     = cmd_q;
        addr_d    = addr_q;
        errCode_d = errCode_q;

        case (state_q)
            IDLE: begin
                if (arm && (ONESHOT != 0)) armPend_d = 1'b1;
                if (rise && armed) state_d = START_HI;
            end
            START_HI: begin
                if (fall) begin
                    if (ticksNow >= START_MIN_T) begin
                        state_d  = GAP;
                        bitpos_d = '0;
                    end else begin
                        state_d   = ERR;
                        errPend_d = 2'd0;
                    end
                end else if (ticksNow >= START_MAX_T) begin
                    state_d   = ERR;
                    errPend_d = 2'd0;
                end
            end
            GAP: begin
                if (rise) begin
                    state_d = BIT_HI;
                end else if (ticksNow >= LOW_MAX_T) begin
                    state_d   = ERR;
                    errPend_d = 2'd2;
                end
            end
            BIT_HI: begin
                if (fall) begin
                    if (ticksNow < HIGH_MIN_T) begin
                        state_d   = ERR;
                        errPend_d = 2'd1;
                    end else begin
                        // Right shift leaves the first received bit at index 0.
                        shift_d = {(ticksNow >= BIT_THRESH_T), shift_q[NBITS-1:1]};
                        if (bitpos_q == LAST_BIT) begin
                            state_d = DONE;
                        end else begin
                            bitpos_d = bitpos_q + 5'd1;
                            state_d  = GAP;
                        end
                    end
                end else if (ticksNow >= HIGH_MAX_T) begin
                    state_d   = ERR;
                    errPend_d = 2'd3;
                end
            end
            DONE: begin
                valid_d   = 1'b1;
                cmd_d     = shift_q[6:0];
                addr_d    = shift_q[NBITS-1:7];
                armPend_d = 1'b0;
                state_d   = IDLE;
            end
            ERR: begin
                error_d   = 1'b1;
                errCode_d = errPend_q;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Width measurement restarts from zero on every state change.
    always_comb begin
        if (state_d != state_q) begin
            presc_d = '0;
            ticks_d = '0;
        end else begin
            presc_d = tickNow ? '0 : presc_q + PW'(1);
            ticks_d = ticksNow;
        end
    end

    assign valid       = valid_q;
    assign error       = error_q;
    assign command     = cmd_q;
    assign address     = addr_q;
    assign err_code    = errCode_q;
    assign busy        = (state_q != IDLE);
    assign debug_state = state_q;

endmodule
